// File: rtl/dual_fetch.sv
// Dual-instruction fetch stage with IF/ID pair register (slot0 = pc, slot1 = pc+4).
// Optional performance counters enabled by defining DUAL_FETCH_PERF_EN.
module dual_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        rewind,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata0,
  input  logic [31:0] imem_rdata1,
  output logic [31:0] imem_addr0,
  output logic [31:0] imem_addr1,
  output logic [31:0] inst0_old,
  output logic [31:0] inst1_old,
  output logic [31:0] pc0_id,
  output logic [31:0] pc1_id,
  output logic        valid0_id,
  output logic        valid1_id
`ifdef DUAL_FETCH_PERF_EN
  ,
  output logic [31:0] perf_pairs,
  output logic [31:0] perf_rewinds
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst0_reg, inst1_reg;
  logic [31:0] pc0_reg, pc1_reg;
  logic        valid_reg;
  logic        load_pair, clear_pair, do_rewind;

  assign imem_addr0 = pc_reg;
  assign imem_addr1 = pc_reg + 32'd4;

  assign inst0_old = inst0_reg;
  assign inst1_old = inst1_reg;
  assign pc0_id    = pc0_reg;
  assign pc1_id    = pc1_reg;
  assign valid0_id = valid_reg;
  assign valid1_id = valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // RUN and WAIT share the same per-edge priority; the state only records
  // whether the last non-stalled edge found memory not ready.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    load_pair  = 1'b0;
    clear_pair = 1'b0;
    do_rewind  = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
        if (flush) begin
          pc_next    = redirect_pc & ~32'd3;
          clear_pair = 1'b1;
        end
      end
      default: begin
        if (flush) begin
          pc_next    = redirect_pc & ~32'd3;
          clear_pair = 1'b1;
          state_next = RUN;
        end else if (stall) begin
          state_next = state_reg;
        end else if (!imem_valid) begin
          clear_pair = 1'b1;
          state_next = WAIT;
        end else begin
          load_pair  = 1'b1;
          do_rewind  = rewind;
          state_next = RUN;
          pc_next    = pc_reg + (rewind ? 32'd4 : 32'd8);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst0_reg <= NOP_WORD;
      inst1_reg <= NOP_WORD;
      pc0_reg   <= 32'd0;
      pc1_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else if (clear_pair) begin
      inst0_reg <= NOP_WORD;
      inst1_reg <= NOP_WORD;
      valid_reg <= 1'b0;
    end else if (load_pair) begin
      inst0_reg <= imem_rdata0;
      inst1_reg <= imem_rdata1;
      pc0_reg   <= pc_reg;
      pc1_reg   <= pc_reg + 32'd4;
      valid_reg <= 1'b1;
    end
  end

`ifdef DUAL_FETCH_PERF_EN
  logic [31:0] perf_pairs_reg, perf_rewinds_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pairs_reg   <= 32'd0;
      perf_rewinds_reg <= 32'd0;
    end else begin
      if (load_pair) perf_pairs_reg <= perf_pairs_reg + 32'd1;
      if (do_rewind) perf_rewinds_reg <= perf_rewinds_reg + 32'd1;
    end
  end

  assign perf_pairs   = perf_pairs_reg;
  assign perf_rewinds = perf_rewinds_reg;
`endif

endmodule

// File: tb/tb_dual_fetch.sv
// Randomized self-checking bench for dual_fetch against a behavioural fetch model.
// Build with DUAL_FETCH_PERF_EN defined to also check the performance counters.
module tb_dual_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, rewind, imem_valid;
  logic [31:0] redirect_pc, imem_rdata0, imem_rdata1;
  logic [31:0] imem_addr0, imem_addr1, inst0_old, inst1_old, pc0_id, pc1_id;
  logic        valid0_id, valid1_id;
`ifdef DUAL_FETCH_PERF_EN
  logic [31:0] perf_pairs, perf_rewinds;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: program counter, boot flag and the decoded pair.
  logic [31:0] m_pc, m_inst0, m_inst1, m_pc0, m_pc1, m_pairs, m_rew;
  logic        m_boot, m_v;

  always #5 clk = ~clk;

  dual_fetch #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .rewind(rewind), .imem_valid(imem_valid), .imem_rdata0(imem_rdata0),
    .imem_rdata1(imem_rdata1), .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
    .inst0_old(inst0_old), .inst1_old(inst1_old), .pc0_id(pc0_id), .pc1_id(pc1_id),
    .valid0_id(valid0_id), .valid1_id(valid1_id)
`ifdef DUAL_FETCH_PERF_EN
    , .perf_pairs(perf_pairs), .perf_rewinds(perf_rewinds)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_boot = 1'b1; m_v = 1'b0;
    m_inst0 = NOP_WORD; m_inst1 = NOP_WORD; m_pc0 = 0; m_pc1 = 0;
    m_pairs = 0; m_rew = 0;
  endtask

  // Drive one cycle of inputs, clock once, then advance the model.
  task automatic cycle(input logic st, input logic fl, input logic [31:0] rpc,
                       input logic rw, input logic iv);
    stall = st; flush = fl; redirect_pc = rpc; rewind = rw; imem_valid = iv;
    imem_rdata0 = iv ? mem_word(m_pc) : $urandom;
    imem_rdata1 = iv ? mem_word(m_pc + 32'd4) : $urandom;
    @(posedge clk);
    #1;
    if (m_boot) begin
      m_boot = 1'b0;
      if (fl) m_pc = {rpc[31:2], 2'b00};
    end else if (fl) begin
      m_pc = {rpc[31:2], 2'b00};
      m_v = 1'b0; m_inst0 = NOP_WORD; m_inst1 = NOP_WORD;
    end else if (st) begin
      // everything held
    end else if (!iv) begin
      m_v = 1'b0; m_inst0 = NOP_WORD; m_inst1 = NOP_WORD;
    end else begin
      m_inst0 = mem_word(m_pc); m_inst1 = mem_word(m_pc + 32'd4);
      m_pc0 = m_pc; m_pc1 = m_pc + 32'd4; m_v = 1'b1;
      m_pc = m_pc + (rw ? 32'd4 : 32'd8);
      m_pairs = m_pairs + 1;
      if (rw) m_rew = m_rew + 1;
    end
  endtask

  task automatic test_reset();
    stall = 1'b1; flush = 1'b0; rewind = 1'b1; imem_valid = 1'b1;
    redirect_pc = 32'h0; imem_rdata0 = $urandom; imem_rdata1 = $urandom;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++; if (imem_addr0 !== RESET_PC) begin errors++; $display("FAIL reset_addr0 got=%h exp=%h", imem_addr0, RESET_PC); end
    checks++; if (imem_addr1 !== RESET_PC + 32'd4) begin errors++; $display("FAIL reset_addr1 got=%h exp=%h", imem_addr1, RESET_PC + 32'd4); end
    checks++; if ({valid0_id, valid1_id} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {valid0_id, valid1_id}); end
    checks++; if (inst0_old !== NOP_WORD || inst1_old !== NOP_WORD) begin errors++; $display("FAIL reset_inst got=%h/%h exp=%h", inst0_old, inst1_old, NOP_WORD); end
    checks++; if (pc0_id !== 32'd0 || pc1_id !== 32'd0) begin errors++; $display("FAIL reset_pcid got=%h/%h exp=0", pc0_id, pc1_id); end
`ifdef DUAL_FETCH_PERF_EN
    checks++; if (perf_pairs !== 0 || perf_rewinds !== 0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0", perf_pairs, perf_rewinds); end
`endif
    $display("reset: addr0=%h valid=%b", imem_addr0, valid0_id);
  endtask

  task automatic test_boot();
    cycle(0, 0, 0, 0, 1);
    checks++; if (valid0_id !== 1'b0 || imem_addr0 !== 32'h100) begin errors++; $display("FAIL boot_cycle got=v%b a%h exp=v0 a00000100", valid0_id, imem_addr0); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== 32'h100 || pc1_id !== 32'h104) begin errors++; $display("FAIL boot_pair got=%h/%h exp=00000100/00000104", pc0_id, pc1_id); end
    checks++; if (imem_addr0 !== 32'h108) begin errors++; $display("FAIL boot_pc got=%h exp=00000108", imem_addr0); end
    checks++; if (inst0_old !== mem_word(32'h100) || inst1_old !== mem_word(32'h104)) begin errors++; $display("FAIL boot_inst got=%h/%h exp=%h/%h", inst0_old, inst1_old, mem_word(32'h100), mem_word(32'h104)); end
    $display("boot: pc0_id=%h pc1_id=%h addr0=%h", pc0_id, pc1_id, imem_addr0);
  endtask

  task automatic test_rewind();
    cycle(0, 0, 0, 1, 1);
    checks++; if (imem_addr0 !== 32'h10C || pc0_id !== 32'h108) begin errors++; $display("FAIL rewind_pc got=a%h p%h exp=a0000010c p00000108", imem_addr0, pc0_id); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== 32'h10C || pc1_id !== 32'h110 || valid1_id !== 1'b1) begin errors++; $display("FAIL rewind_refetch got=%h/%h v%b exp=0000010c/00000110 v1", pc0_id, pc1_id, valid1_id); end
    $display("rewind: pc0_id=%h pc1_id=%h addr0=%h", pc0_id, pc1_id, imem_addr0);
  endtask

  task automatic test_flush_stall();
    cycle(1, 1, 32'h2003, 1, 1);
    checks++; if (imem_addr0 !== 32'h2000) begin errors++; $display("FAIL flush_pc got=%h exp=00002000", imem_addr0); end
    checks++; if (inst0_old !== NOP_WORD || inst1_old !== NOP_WORD || valid0_id !== 1'b0 || valid1_id !== 1'b0) begin errors++; $display("FAIL flush_squash got=%h/%h v%b%b exp=%h v00", inst0_old, inst1_old, valid0_id, valid1_id, NOP_WORD); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== 32'h2000 || valid0_id !== 1'b1 || inst0_old !== mem_word(32'h2000)) begin errors++; $display("FAIL flush_target got=%h v%b exp=00002000 v1", pc0_id, valid0_id); end
    $display("flush: pc0_id=%h valid=%b", pc0_id, valid0_id);
  endtask

  task automatic test_wait();
    cycle(0, 1, 32'h40, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      checks++; if (imem_addr0 !== 32'h40 || valid0_id !== 1'b0 || inst0_old !== NOP_WORD) begin errors++; $display("FAIL wait_hold%0d got=a%h v%b exp=a00000040 v0", i, imem_addr0, valid0_id); end
    end
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== 32'h40 || pc1_id !== 32'h44 || valid1_id !== 1'b1 || imem_addr0 !== 32'h48) begin errors++; $display("FAIL wait_resume got=%h/%h a%h exp=00000040/00000044 a00000048", pc0_id, pc1_id, imem_addr0); end
    $display("wait: resumed pc0_id=%h", pc0_id);
  endtask

  task automatic test_stall_rewind();
    logic [31:0] pc_s, i0_s, i1_s, p0_s;
    pc_s = m_pc; i0_s = m_inst0; i1_s = m_inst1; p0_s = m_pc0;
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 1, 1);
      checks++; if (imem_addr0 !== pc_s || inst0_old !== i0_s || inst1_old !== i1_s || pc0_id !== p0_s || valid0_id !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got=a%h p%h exp=a%h p%h", i, imem_addr0, pc0_id, pc_s, p0_s); end
    end
    cycle(0, 0, 0, 1, 1);
    checks++; if (pc0_id !== pc_s || imem_addr0 !== pc_s + 32'd4) begin errors++; $display("FAIL stall_release got=p%h a%h exp=p%h a%h", pc0_id, imem_addr0, pc_s, pc_s + 32'd4); end
    $display("stall: released pc0_id=%h addr0=%h", pc0_id, imem_addr0);
  endtask

  task automatic test_wrap();
`ifdef DUAL_FETCH_PERF_EN
    logic [31:0] pairs_before;
`endif
    cycle(0, 1, 32'hFFFF_FFFB, 0, 1);
`ifdef DUAL_FETCH_PERF_EN
    pairs_before = perf_pairs;
`endif
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== 32'hFFFF_FFF8 || pc1_id !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pair got=%h/%h exp=fffffff8/fffffffc", pc0_id, pc1_id); end
    checks++; if (imem_addr0 !== 32'h0 || imem_addr1 !== 32'h4) begin errors++; $display("FAIL wrap_pc got=%h/%h exp=0/4", imem_addr0, imem_addr1); end
`ifdef DUAL_FETCH_PERF_EN
    checks++; if (perf_pairs !== pairs_before + 32'd1) begin errors++; $display("FAIL wrap_perf got=%0d exp=%0d", perf_pairs, pairs_before + 32'd1); end
`endif
    $display("wrap: pc1_id=%h addr0=%h", pc1_id, imem_addr0);
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
      bad = 0;
      if (imem_addr0 !== m_pc || imem_addr1 !== m_pc + 32'd4) bad = 1;
      if (valid0_id !== m_v || valid1_id !== m_v) bad = 1;
      if (inst0_old !== m_inst0 || inst1_old !== m_inst1) bad = 1;
      if (m_v && (pc0_id !== m_pc0 || pc1_id !== m_pc1)) bad = 1;
`ifdef DUAL_FETCH_PERF_EN
      if (perf_pairs !== m_pairs || perf_rewinds !== m_rew) bad = 1;
`endif
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random%0d got=a%h v%b i%h p%h exp=a%h v%b i%h p%h", n, imem_addr0, valid0_id, inst0_old, pc0_id, m_pc, m_v, m_inst0, m_pc0);
      end
    end
    $display("random: 400 cycles, final addr0=%h", imem_addr0);
  endtask

  task automatic test_reset_mid_wait();
    cycle(0, 0, 0, 0, 0);
    test_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++; if (pc0_id !== RESET_PC || valid0_id !== 1'b1) begin errors++; $display("FAIL reset_mid_wait got=%h v%b exp=%h v1", pc0_id, valid0_id, RESET_PC); end
    $display("reset_mid_wait: pc0_id=%h", pc0_id);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; rewind = 1'b0; imem_valid = 1'b0;
    redirect_pc = 32'h0; imem_rdata0 = 32'h0; imem_rdata1 = 32'h0;
    model_reset();
    test_reset();
    test_boot();
    test_rewind();
    test_flush_stall();
    test_wait();
    test_stall_rewind();
    test_wrap();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
